neuron_scheduler: RTL and testbench

Time-multiplexes one shared combinational LIF `neuron` datapath across `N_NEURONS` virtual neurons. Holds per-neuron configuration (weights, threshold, leak shift) and state (membrane potential, last spike) in local registers. On each `step` it presents every neuron to the datapath in turn, one per cycle, writes back the results, and publishes the timestep's spike vector. It sits between the top-level I/O wrapper and the `neuron` instance, replacing the wrapper's single fixed-neuron registers.

---
 rtl/neuron_scheduler_if.sv | 46 ++++
 rtl/neuron_scheduler.sv | 171 +++++++++++++++++
 tb/tb_neuron_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/neuron_scheduler_if.sv
// rtl/neuron_scheduler_if.sv - host and datapath signal bundle for neuron_scheduler
interface neuron_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int INPUTS    = 4,
  parameter int U_W       = 4
);
  localparam int ADDR_W = $clog2(N_NEURONS);

  // host side: configuration and timestep control
  logic                 cfg_we;
  logic [ADDR_W-1:0]    cfg_addr;
  logic [INPUTS-1:0]    cfg_w;
  logic [U_W-1:0]       cfg_minus_teta;
  logic [2:0]           cfg_shift;
  logic                 step;
  logic [INPUTS-1:0]    x_in;
  logic                 busy;
  logic                 done;
  logic [N_NEURONS-1:0] spikes;
  logic                 overrun;
  logic                 cfg_err;

  // datapath side: operands out, combinational results back
  logic [INPUTS-1:0]    dp_w;
  logic [INPUTS-1:0]    dp_x;
  logic [2:0]           dp_shift;
  logic [U_W-1:0]       dp_previus_u;
  logic [U_W-1:0]       dp_minus_teta;
  logic                 dp_was_spike;
  logic [U_W-1:0]       dp_u_out;
  logic                 dp_is_spike;

  modport master (
    output cfg_we, cfg_addr, cfg_w, cfg_minus_teta, cfg_shift, step, x_in,
    output dp_u_out, dp_is_spike,
    input  busy, done, spikes, overrun, cfg_err,
    input  dp_w, dp_x, dp_shift, dp_previus_u, dp_minus_teta, dp_was_spike
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_w, cfg_minus_teta, cfg_shift, step, x_in,
    input  dp_u_out, dp_is_spike,
    output busy, done, spikes, overrun, cfg_err,
    output dp_w, dp_x, dp_shift, dp_previus_u, dp_minus_teta, dp_was_spike
  );
endinterface

// File: rtl/neuron_scheduler.sv
// rtl/neuron_scheduler.sv - time-multiplexes one LIF datapath over N_NEURONS virtual neurons
// Optional feature: NEURON_SCHED_REFRACTORY_EN skips a neuron for one slot after it spiked.
module neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int N_STAGES  = 2,
  parameter int INPUTS    = 2**N_STAGES,
  parameter int U_W       = N_STAGES + 2
) (
  input  logic              clk,
  input  logic              reset,
  neuron_scheduler_if.slave bus
);
  localparam int                IDX_W          = $clog2(N_NEURONS);
  localparam logic [U_W-1:0]    MINUS_TETA_RST = U_W'(-5);
  localparam logic [IDX_W-1:0]  LAST_IDX       = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [INPUTS-1:0]    x_q, x_d;
  logic [INPUTS-1:0]    w_q          [N_NEURONS];
  logic [INPUTS-1:0]    w_d          [N_NEURONS];
  logic [U_W-1:0]       minus_teta_q [N_NEURONS];
  logic [U_W-1:0]       minus_teta_d [N_NEURONS];
  logic [2:0]           shift_q      [N_NEURONS];
  logic [2:0]           shift_d      [N_NEURONS];
  logic [U_W-1:0]       u_q          [N_NEURONS];
  logic [U_W-1:0]       u_d          [N_NEURONS];
  logic [N_NEURONS-1:0] was_spike_q, was_spike_d;
  logic [N_NEURONS-1:0] acc_q, acc_d;
  logic [N_NEURONS-1:0] spikes_q, spikes_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 cfg_ok;
  logic                 slot_refr;

`ifdef NEURON_SCHED_REFRACTORY_EN
  // a neuron that spiked last timestep sits out its slot this timestep
  assign slot_refr = (state_q == S_EVAL) && was_spike_q[idx_q];
`else
  assign slot_refr = 1'b0;
`endif

  // present neuron idx to the shared datapath during EVAL, zeros otherwise
  always_comb begin
    bus.dp_w          = '0;
    bus.dp_x          = '0;
    bus.dp_shift      = '0;
    bus.dp_previus_u  = '0;
    bus.dp_minus_teta = '0;
    bus.dp_was_spike  = 1'b0;
    if (state_q == S_EVAL && !slot_refr) begin
      bus.dp_w          = w_q[idx_q];
      bus.dp_x          = x_q;
      bus.dp_shift      = shift_q[idx_q];
      bus.dp_previus_u  = u_q[idx_q];
      bus.dp_minus_teta = minus_teta_q[idx_q];
      bus.dp_was_spike  = was_spike_q[idx_q];
    end
  end

  // next-state: config writes, step acceptance, slot write-back, drop flags
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    x_d          = x_q;
    w_d          = w_q;
    minus_teta_d = minus_teta_q;
    shift_d      = shift_q;
    u_d          = u_q;
    was_spike_d  = was_spike_q;
    acc_d        = acc_q;
    spikes_d     = spikes_q;
    overrun_d    = overrun_q;
    cfg_err_d    = cfg_err_q;
    cfg_ok       = (state_q == S_IDLE) && (int'(bus.cfg_addr) < N_NEURONS);

    if (bus.cfg_we) begin
      if (cfg_ok) begin
        w_d[bus.cfg_addr]          = bus.cfg_w;
        minus_teta_d[bus.cfg_addr] = bus.cfg_minus_teta;
        shift_d[bus.cfg_addr]      = bus.cfg_shift;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.step) begin
          x_d     = bus.x_in;
          idx_d   = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (bus.step) overrun_d = 1'b1;
        if (slot_refr) begin
          u_d[idx_q]         = '0;
          was_spike_d[idx_q] = 1'b0;
          acc_d[idx_q]       = 1'b0;
        end else begin
          u_d[idx_q]         = bus.dp_u_out;
          was_spike_d[idx_q] = bus.dp_is_spike;
          acc_d[idx_q]       = bus.dp_is_spike;
        end
        // spikes must already be visible in the DONE cycle, so load on the last slot edge
        if (idx_q == LAST_IDX) begin
          state_d  = S_DONE;
          spikes_d = acc_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.step) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      was_spike_q <= '0;
      acc_q       <= '0;
      spikes_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        w_q[i]          <= '0;
        minus_teta_q[i] <= MINUS_TETA_RST;
        shift_q[i]      <= '0;
        u_q[i]          <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      x_q          <= x_d;
      w_q          <= w_d;
      minus_teta_q <= minus_teta_d;
      shift_q      <= shift_d;
      u_q          <= u_d;
      was_spike_q  <= was_spike_d;
      acc_q        <= acc_d;
      spikes_q     <= spikes_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.spikes  = spikes_q;
  assign bus.overrun = overrun_q;
  assign bus.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_neuron_scheduler.sv
// tb/tb_neuron_scheduler.sv - directed self-checking bench for neuron_scheduler with stub datapath
module tb_neuron_scheduler;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [3:0] prev_spk;

  neuron_scheduler_if #(.N_NEURONS(4), .INPUTS(4), .U_W(4)) sif ();

  neuron_scheduler #(.N_NEURONS(4), .N_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  // stub datapath: u+1, spike when weight bit 0 and input bit 0 are both set
  assign sif.dp_u_out    = sif.dp_previus_u + 4'd1;
  assign sif.dp_is_spike = sif.dp_w[0] & sif.dp_x[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [3:0] w, input logic [3:0] mt,
                           input logic [2:0] sh);
    sif.cfg_we = 1'b1; sif.cfg_addr = a; sif.cfg_w = w;
    sif.cfg_minus_teta = mt; sif.cfg_shift = sh;
    tick();
    sif.cfg_we = 1'b0;
  endtask

  // one full timestep; e_* pack slot k at bits [k*width +: width]
  task automatic run_step(input logic [3:0] x, input logic [15:0] e_w, input logic [15:0] e_u,
                          input logic [15:0] e_mt, input logic [11:0] e_sh,
                          input logic [3:0] e_refr, input logic [3:0] e_spk,
                          input int inj_step, input int inj_cfg);
    logic z;
    sif.step = 1'b1; sif.x_in = x;
    tick();
    sif.step = 1'b0; sif.cfg_we = 1'b0; sif.x_in = '0;
    for (int c = 1; c <= 4; c++) begin
      z = e_refr[c-1];
      check($sformatf("busy T+%0d", c), 32'(sif.busy), 32'd1);
      check($sformatf("done T+%0d", c), 32'(sif.done), 32'd0);
      check($sformatf("spikes hold T+%0d", c), 32'(sif.spikes), 32'(prev_spk));
      check($sformatf("dp_w s%0d", c-1), 32'(sif.dp_w), z ? 32'd0 : 32'(e_w[(c-1)*4 +: 4]));
      check($sformatf("dp_x s%0d", c-1), 32'(sif.dp_x), z ? 32'd0 : 32'(x));
      check($sformatf("dp_previus_u s%0d", c-1), 32'(sif.dp_previus_u),
            z ? 32'd0 : 32'(e_u[(c-1)*4 +: 4]));
      check($sformatf("dp_minus_teta s%0d", c-1), 32'(sif.dp_minus_teta),
            z ? 32'd0 : 32'(e_mt[(c-1)*4 +: 4]));
      check($sformatf("dp_shift s%0d", c-1), 32'(sif.dp_shift),
            z ? 32'd0 : 32'(e_sh[(c-1)*3 +: 3]));
      if (c == inj_step - 1) sif.step = 1'b1;
      if (c == inj_step) sif.step = 1'b0;
      if (c == inj_cfg - 1) begin
        sif.cfg_we = 1'b1; sif.cfg_addr = 2'd3; sif.cfg_w = 4'hF;
        sif.cfg_minus_teta = 4'h0; sif.cfg_shift = 3'd7;
      end
      if (c == inj_cfg) sif.cfg_we = 1'b0;
      tick();
    end
    check("done T+5", 32'(sif.done), 32'd1);
    check("busy T+5", 32'(sif.busy), 32'd1);
    check("spikes T+5", 32'(sif.spikes), 32'(e_spk));
    check("dp_w DONE", 32'(sif.dp_w), 32'd0);
    prev_spk = e_spk;
    tick();
    check("busy T+6", 32'(sif.busy), 32'd0);
    check("done T+6", 32'(sif.done), 32'd0);
    check("spikes T+6", 32'(sif.spikes), 32'(e_spk));
  endtask

  initial begin
    checks = 0; failures = 0; prev_spk = 4'b0000;
    reset = 1'b0;
    sif.cfg_we = 1'b0; sif.cfg_addr = '0; sif.cfg_w = '0;
    sif.cfg_minus_teta = '0; sif.cfg_shift = '0; sif.step = 1'b0; sif.x_in = '0;

    // asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst busy", 32'(sif.busy), 32'd0);
    check("rst done", 32'(sif.done), 32'd0);
    check("rst spikes", 32'(sif.spikes), 32'd0);
    check("rst overrun", 32'(sif.overrun), 32'd0);
    check("rst cfg_err", 32'(sif.cfg_err), 32'd0);
    check("rst dp_minus_teta", 32'(sif.dp_minus_teta), 32'd0);
    check("rst dp_w", 32'(sif.dp_w), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // reset config: minus_teta -5 everywhere, weights and u zero
    run_step(4'b0000, 16'h0000, 16'h0000, 16'hBBBB, 12'h000, 4'b0000, 4'b0000, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("rst2 busy", 32'(sif.busy), 32'd0);
    check("rst2 spikes", 32'(sif.spikes), 32'd0);
    #2 reset = 1'b0;
    tick();

    // configure: only neuron 2 has weight bit 0
    cfg_write(2'd0, 4'b0000, 4'b1110, 3'd1);
    cfg_write(2'd1, 4'b0000, 4'b1101, 3'd2);
    cfg_write(2'd2, 4'b0001, 4'b1100, 3'd3);
    cfg_write(2'd3, 4'b0000, 4'b1111, 3'd4);
    check("cfg_err after good writes", 32'(sif.cfg_err), 32'd0);

    run_step(4'b0001, 16'h0100, 16'h0000, 16'hFCDE, 12'h8D1, 4'b0000, 4'b0100, 0, 0);
`ifdef NEURON_SCHED_REFRACTORY_EN
    run_step(4'b0001, 16'h0100, 16'h1111, 16'hFCDE, 12'h8D1, 4'b0100, 4'b0000, 0, 0);
`else
    run_step(4'b0001, 16'h0100, 16'h1111, 16'hFCDE, 12'h8D1, 4'b0000, 4'b0100, 0, 0);
`endif
    check("overrun clear", 32'(sif.overrun), 32'd0);
    check("cfg_err clear", 32'(sif.cfg_err), 32'd0);

    // dropped step at T+2 and dropped config write at T+3
`ifdef NEURON_SCHED_REFRACTORY_EN
    run_step(4'b0001, 16'h0100, 16'h2022, 16'hFCDE, 12'h8D1, 4'b0000, 4'b0100, 2, 3);
`else
    run_step(4'b0001, 16'h0100, 16'h2222, 16'hFCDE, 12'h8D1, 4'b0000, 4'b0100, 2, 3);
`endif
    check("overrun set", 32'(sif.overrun), 32'd1);
    check("cfg_err set", 32'(sif.cfg_err), 32'd1);
    tick();
    check("no extra step busy", 32'(sif.busy), 32'd0);

    // weights unchanged after dropped write
`ifdef NEURON_SCHED_REFRACTORY_EN
    run_step(4'b0001, 16'h0100, 16'h3333, 16'hFCDE, 12'h8D1, 4'b0100, 4'b0000, 0, 0);
`else
    run_step(4'b0001, 16'h0100, 16'h3333, 16'hFCDE, 12'h8D1, 4'b0000, 4'b0100, 0, 0);
`endif
    check("overrun sticky", 32'(sif.overrun), 32'd1);

    // reset mid-EVAL at T+2
    sif.step = 1'b1; sif.x_in = 4'b0001;
    tick();
    sif.step = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check("midrst busy", 32'(sif.busy), 32'd0);
    check("midrst done", 32'(sif.done), 32'd0);
    check("midrst spikes", 32'(sif.spikes), 32'd0);
    check("midrst dp_w", 32'(sif.dp_w), 32'd0);
    check("midrst overrun", 32'(sif.overrun), 32'd0);
    check("midrst cfg_err", 32'(sif.cfg_err), 32'd0);
    #2 reset = 1'b0;
    prev_spk = 4'b0000;
    tick();

    // simultaneous step and config write in IDLE; u all zero after reset
    sif.cfg_we = 1'b1; sif.cfg_addr = 2'd1; sif.cfg_w = 4'b0001;
    sif.cfg_minus_teta = 4'b1010; sif.cfg_shift = 3'd5;
    run_step(4'b0001, 16'h0010, 16'h0000, 16'hBBAB, 12'h028, 4'b0000, 4'b0010, 0, 0);
    check("cfg_err after idle write", 32'(sif.cfg_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
